// File: rtl/el2_pkg.sv
// Shared types for the IFU ICCM arbiter: arbiter FSM states and DMA size encodings.
package el2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DMA_RD,
        RMW_RD,
        RMW_WR
    } el2_iccm_arb_state_t;

    localparam logic [2:0] ICCM_SZ_B = 3'd0;
    localparam logic [2:0] ICCM_SZ_H = 3'd1;
    localparam logic [2:0] ICCM_SZ_W = 3'd2;
    localparam logic [2:0] ICCM_SZ_D = 3'd3;

endpackage

// File: rtl/el2_ifu_iccm_merge.sv
// Byte-lane merge of a sub-doubleword DMA write into the doubleword read back from ICCM.
module el2_ifu_iccm_merge
    import el2_pkg::*;
(
    input  logic [63:0] rd_data,
    input  logic [63:0] wdata,
    input  logic [2:0]  addr,
    input  logic [2:0]  sz,
    output logic [63:0] merged
);

    logic [5:0]  shamt;
    logic [63:0] lane_mask;
    logic [63:0] placed_mask;

    // Address bits below the access size are dropped so the lane stays naturally aligned.
    always_comb begin
        shamt     = '0;
        lane_mask = '1;
        case (sz)
            ICCM_SZ_B: begin
                shamt     = {addr, 3'b000};
                lane_mask = 64'h0000_0000_0000_00FF;
            end
            ICCM_SZ_H: begin
                shamt     = {addr[2:1], 4'b0000};
                lane_mask = 64'h0000_0000_0000_FFFF;
            end
            ICCM_SZ_W: begin
                shamt     = {addr[2], 5'b00000};
                lane_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                shamt     = '0;
                lane_mask = '1;
            end
        endcase
        placed_mask = lane_mask << shamt;
        merged      = (rd_data & ~placed_mask) | ((wdata << shamt) & placed_mask);
    end

endmodule

// File: rtl/el2_ifu_iccm_arb.sv
// ICCM port arbiter between instruction fetch and DMA, with read-modify-write for narrow DMA writes.
// Define RV_ICCM_ARB_STARVE_EN to let a starved fetch win over DMA after STARVE_MAX denied cycles.
module el2_ifu_iccm_arb
    import el2_pkg::*;
#(
    parameter int unsigned ICCM_AW    = 18,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              fetch_req_bf,
    input  logic [31:1]       fetch_addr_bf,
    output logic              fetch_gnt,
    input  logic              dma_req,
    input  logic [31:0]       dma_addr,
    input  logic [2:0]        dma_sz,
    input  logic              dma_write,
    input  logic [63:0]       dma_wdata,
    input  logic [2:0]        dma_tag,
    output logic              dma_gnt,
    output logic [ICCM_AW:1]  iccm_rw_addr,
    output logic              iccm_rden,
    output logic              iccm_wren,
    output logic [63:0]       iccm_wr_data,
    output logic [2:0]        iccm_wr_size,
    input  logic [63:0]       iccm_rd_data,
    output logic              dma_rvalid,
    output logic [63:0]       dma_rdata,
    output logic [2:0]        dma_rtag,
    output logic              iccm_dma_active,
    output logic              arb_idle
);

    el2_iccm_arb_state_t state_q, state_d;

    logic [ICCM_AW:0] addr_q;
    logic [2:0]       sz_q;
    logic [2:0]       tag_q;
    logic [63:0]      wdata_q;
    logic [63:0]      rdata_q;
    logic             rvalid_q;
    logic [63:0]      merged;
    logic             fetch_starved;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{fetch_addr_bf[31:ICCM_AW+1], dma_addr[31:ICCM_AW+1]};

`ifdef RV_ICCM_ARB_STARVE_EN
    logic [2:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            starve_cnt <= '0;
        end else if (!fetch_req_bf || fetch_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    assign fetch_starved = ({29'b0, starve_cnt} >= STARVE_MAX);
`else
    assign fetch_starved = 1'b0;
`endif

    el2_ifu_iccm_merge u_merge (
        .rd_data (iccm_rd_data),
        .wdata   (wdata_q),
        .addr    (addr_q[2:0]),
        .sz      (sz_q),
        .merged  (merged)
    );

    // Grants are gated by rst_l so every output is quiet while reset is held.
    always_comb begin
        state_d      = state_q;
        fetch_gnt    = 1'b0;
        dma_gnt      = 1'b0;
        iccm_rden    = 1'b0;
        iccm_wren    = 1'b0;
        iccm_rw_addr = '0;
        iccm_wr_data = '0;
        iccm_wr_size = '0;
        unique case (state_q)
            IDLE: begin
                if (rst_l) begin
                    if (dma_req && !(fetch_req_bf && fetch_starved)) begin
                        dma_gnt      = 1'b1;
                        iccm_rw_addr = dma_addr[ICCM_AW:1];
                        if (dma_write && (dma_sz == ICCM_SZ_D)) begin
                            iccm_wren    = 1'b1;
                            iccm_wr_data = dma_wdata;
                            iccm_wr_size = ICCM_SZ_D;
                        end else begin
                            iccm_rden = 1'b1;
                            state_d   = dma_write ? RMW_RD : DMA_RD;
                        end
                    end else if (fetch_req_bf) begin
                        fetch_gnt    = 1'b1;
                        iccm_rden    = 1'b1;
                        iccm_rw_addr = fetch_addr_bf[ICCM_AW:1];
                    end
                end
            end
            DMA_RD: begin
                iccm_rw_addr = addr_q[ICCM_AW:1];
                state_d      = IDLE;
            end
            RMW_RD: begin
                iccm_rw_addr = addr_q[ICCM_AW:1];
                state_d      = RMW_WR;
            end
            RMW_WR: begin
                iccm_rw_addr = addr_q[ICCM_AW:1];
                iccm_wren    = 1'b1;
                iccm_wr_data = wdata_q;
                iccm_wr_size = ICCM_SZ_D;
                state_d      = IDLE;
            end
        endcase
    end

    // wdata_q carries the raw DMA data into RMW_RD and the merged doubleword into RMW_WR.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sz_q     <= '0;
            tag_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= (state_q == DMA_RD);
            if (dma_gnt) begin
                addr_q  <= dma_addr[ICCM_AW:0];
                sz_q    <= dma_sz;
                tag_q   <= dma_tag;
                wdata_q <= dma_wdata;
            end
            if (state_q == DMA_RD) begin
                rdata_q <= iccm_rd_data;
            end
            if (state_q == RMW_RD) begin
                wdata_q <= merged;
            end
        end
    end

    assign dma_rvalid      = rvalid_q;
    assign dma_rdata       = rdata_q;
    assign dma_rtag        = tag_q;
    assign iccm_dma_active = (state_q != IDLE);
    assign arb_idle        = (state_q == IDLE);

endmodule

// File: tb/tb_el2_ifu_iccm_arb.sv
// Bench for el2_ifu_iccm_arb: ICCM memory model, transaction-level reference model, directed scenarios.
module tb_el2_ifu_iccm_arb;

    localparam int unsigned AW   = 18;
    localparam int unsigned SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          fetch_req_bf;
    logic [31:1]   fetch_addr_bf;
    logic          fetch_gnt;
    logic          dma_req;
    logic [31:0]   dma_addr;
    logic [2:0]    dma_sz;
    logic          dma_write;
    logic [63:0]   dma_wdata;
    logic [2:0]    dma_tag;
    logic          dma_gnt;
    logic [AW:1]   iccm_rw_addr;
    logic          iccm_rden;
    logic          iccm_wren;
    logic [63:0]   iccm_wr_data;
    logic [2:0]    iccm_wr_size;
    logic [63:0]   iccm_rd_data = '0;
    logic          dma_rvalid;
    logic [63:0]   dma_rdata;
    logic [2:0]    dma_rtag;
    logic          iccm_dma_active;
    logic          arb_idle;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [63:0] mem [int unsigned];

    always #5 clk = ~clk;

    el2_ifu_iccm_arb #(.ICCM_AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .fetch_req_bf    (fetch_req_bf),
        .fetch_addr_bf   (fetch_addr_bf),
        .fetch_gnt       (fetch_gnt),
        .dma_req         (dma_req),
        .dma_addr        (dma_addr),
        .dma_sz          (dma_sz),
        .dma_write       (dma_write),
        .dma_wdata       (dma_wdata),
        .dma_tag         (dma_tag),
        .dma_gnt         (dma_gnt),
        .iccm_rw_addr    (iccm_rw_addr),
        .iccm_rden       (iccm_rden),
        .iccm_wren       (iccm_wren),
        .iccm_wr_data    (iccm_wr_data),
        .iccm_wr_size    (iccm_wr_size),
        .iccm_rd_data    (iccm_rd_data),
        .dma_rvalid      (dma_rvalid),
        .dma_rdata       (dma_rdata),
        .dma_rtag        (dma_rtag),
        .iccm_dma_active (iccm_dma_active),
        .arb_idle        (arb_idle)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_rd(input int unsigned idx);
        if (mem.exists(idx)) return mem[idx];
        return {32'h5A00_0000 | idx, ~idx};
    endfunction

    function automatic logic [63:0] model_merge(input logic [63:0] old, input logic [63:0] wd,
                                                input logic [2:0] a, input logic [2:0] sz);
        int unsigned nbytes;
        int unsigned base;
        logic [63:0] r;
        nbytes = 32'd1 << sz;
        base   = (32'(a) / nbytes) * nbytes;
        r      = old;
        for (int unsigned i = 0; i < nbytes; i++) r[8*(base+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // ICCM behaviour: read data appears the cycle after rden; writes land at the clock edge.
    initial begin : iccm_mem
        forever begin
            @(posedge clk);
            if (rst_l && iccm_rden) iccm_rd_data <= mem_rd(32'(iccm_rw_addr) >> 2);
            if (rst_l && iccm_wren) mem[32'(iccm_rw_addr) >> 2] = iccm_wr_data;
        end
    end

    // Reference model: transaction timing expressed as "busy until" and scheduled completions.
    initial begin : compare
        int          free_at, rv_at, wr_at, starve;
        logic [63:0] rv_data, wr_data_e, e_wdat, dw;
        logic [2:0]  rv_tag;
        logic [AW:1] wr_addr_e, e_addr;
        logic        e_fg, e_dg, e_rd, e_wr, e_active, starving;
        free_at = 0; rv_at = -1; wr_at = -1; starve = 0;
        rv_data = '0; wr_data_e = '0; rv_tag = '0; wr_addr_e = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_l) begin
                chk("rst_fetch_gnt", 64'(fetch_gnt), 64'd0);
                chk("rst_dma_gnt", 64'(dma_gnt), 64'd0);
                chk("rst_rden", 64'(iccm_rden), 64'd0);
                chk("rst_wren", 64'(iccm_wren), 64'd0);
                chk("rst_addr", 64'(iccm_rw_addr), 64'd0);
                chk("rst_wr_data", iccm_wr_data, 64'd0);
                chk("rst_wr_size", 64'(iccm_wr_size), 64'd0);
                chk("rst_rvalid", 64'(dma_rvalid), 64'd0);
                chk("rst_rdata", dma_rdata, 64'd0);
                chk("rst_rtag", 64'(dma_rtag), 64'd0);
                chk("rst_active", 64'(iccm_dma_active), 64'd0);
                chk("rst_arb_idle", 64'(arb_idle), 64'd1);
                free_at = 0; rv_at = -1; wr_at = -1; starve = 0;
            end else begin
                e_fg = 1'b0; e_dg = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
                e_addr = '0; e_wdat = '0;
                e_active = (cyc < free_at);
                if (!e_active) begin
                    starving = 1'b0;
`ifdef RV_ICCM_ARB_STARVE_EN
                    starving = (starve >= int'(SMAX));
`endif
                    if (dma_req && !(fetch_req_bf && starving)) begin
                        e_dg   = 1'b1;
                        e_addr = dma_addr[AW:1];
                        if (dma_write && dma_sz == 3'd3) begin
                            e_wr    = 1'b1;
                            e_wdat  = dma_wdata;
                            free_at = cyc + 1;
                        end else begin
                            e_rd = 1'b1;
                            dw   = mem_rd(32'(dma_addr[AW:3]));
                            if (dma_write) begin
                                wr_at     = cyc + 2;
                                wr_addr_e = dma_addr[AW:1];
                                wr_data_e = model_merge(dw, dma_wdata, dma_addr[2:0], dma_sz);
                                free_at   = cyc + 3;
                            end else begin
                                rv_at   = cyc + 2;
                                rv_data = dw;
                                rv_tag  = dma_tag;
                                free_at = cyc + 2;
                            end
                        end
                    end else if (fetch_req_bf) begin
                        e_fg   = 1'b1;
                        e_rd   = 1'b1;
                        e_addr = fetch_addr_bf[AW:1];
                    end
                end else if (cyc == wr_at) begin
                    e_wr   = 1'b1;
                    e_addr = wr_addr_e;
                    e_wdat = wr_data_e;
                end
                if (fetch_req_bf && !e_fg) starve = (starve < 7) ? starve + 1 : 7;
                else starve = 0;

                chk("fetch_gnt", 64'(fetch_gnt), 64'(e_fg));
                chk("dma_gnt", 64'(dma_gnt), 64'(e_dg));
                chk("iccm_rden", 64'(iccm_rden), 64'(e_rd));
                chk("iccm_wren", 64'(iccm_wren), 64'(e_wr));
                if (e_rd || e_wr) chk("iccm_rw_addr", 64'(iccm_rw_addr), 64'(e_addr));
                if (e_wr) begin
                    chk("iccm_wr_data", iccm_wr_data, e_wdat);
                    chk("iccm_wr_size", 64'(iccm_wr_size), 64'd3);
                end
                chk("dma_rvalid", 64'(dma_rvalid), 64'(cyc == rv_at));
                if (cyc == rv_at) begin
                    chk("dma_rdata", dma_rdata, rv_data);
                    chk("dma_rtag", 64'(dma_rtag), 64'(rv_tag));
                end
                chk("iccm_dma_active", 64'(iccm_dma_active), 64'(e_active));
                chk("arb_idle", 64'(arb_idle), 64'(!e_active));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at grant+1 with the request dropped and attributes scrambled.
    task automatic dma_do(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                          input logic [63:0] wd, input logic [2:0] tag,
                          output logic g_rden, output logic g_wren, output logic g_fgnt,
                          output logic [AW:1] g_addr);
        int n;
        n = 0;
        dma_req = 1'b1; dma_addr = a; dma_sz = sz; dma_write = wr; dma_wdata = wd; dma_tag = tag;
        @(negedge clk);
        while (!dma_gnt && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("dma_grant_wait", 64'(dma_gnt), 64'd1);
        g_rden = iccm_rden; g_wren = iccm_wren; g_fgnt = fetch_gnt; g_addr = iccm_rw_addr;
        step();
        dma_req = 1'b0; dma_addr = 32'hFFFF_FFF8; dma_sz = 3'd0; dma_write = 1'b0;
        dma_wdata = '1; dma_tag = 3'd7;
    endtask

    task automatic read_check(input logic [31:0] a, input logic [2:0] tag, input logic [63:0] exp);
        logic r, w, f;
        logic [AW:1] ga;
        dma_do(a, 3'd3, 1'b0, '0, tag, r, w, f, ga);
        chk("rd_grant_rden", 64'(r), 64'd1);
        chk("rd_grant_addr", 64'(ga), 64'(a[AW:1]));
        @(negedge clk);
        chk("rd_n1_rvalid", 64'(dma_rvalid), 64'd0);
        step();
        @(negedge clk);
        chk("rd_n2_rvalid", 64'(dma_rvalid), 64'd1);
        chk("rd_n2_rtag", 64'(dma_rtag), 64'(tag));
        chk("rd_n2_rdata", dma_rdata, exp);
        step();
    endtask

    task automatic rmw_check(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd,
                             input logic [2:0] tag, input logic [63:0] exp);
        logic r, w, f;
        logic [AW:1] ga;
        dma_do(a, sz, 1'b1, wd, tag, r, w, f, ga);
        chk("rmw_grant_rden", 64'(r), 64'd1);
        chk("rmw_grant_wren", 64'(w), 64'd0);
        @(negedge clk);
        chk("rmw_n1_wren", 64'(iccm_wren), 64'd0);
        step();
        @(negedge clk);
        chk("rmw_n2_wren", 64'(iccm_wren), 64'd1);
        chk("rmw_n2_data", iccm_wr_data, exp);
        chk("rmw_n2_addr", 64'(iccm_rw_addr), 64'(a[AW:1]));
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        logic        r, w, f;
        logic [AW:1] ga;
        int          gcount, gfirst, glast;
        logic [31:1] fa [3];
        logic [AW:1] ea [3];
        fa[0] = 31'h0004_0123; ea[0] = 18'h00123;
        fa[1] = 31'h7FFF_FFFF; ea[1] = 18'h3FFFF;
        fa[2] = 31'h0000_2AAA; ea[2] = 18'h02AAA;

        rst_l = 1'b0; fetch_req_bf = 1'b1; fetch_addr_bf = 31'h1234;
        dma_req = 1'b1; dma_addr = 32'h40; dma_sz = 3'd0; dma_write = 1'b0;
        dma_wdata = '0; dma_tag = 3'd3;
        repeat (3) step();
        @(negedge clk);
        chk("reset_arb_idle", 64'(arb_idle), 64'd1);
        chk("reset_fetch_gnt", 64'(fetch_gnt), 64'd0);
        step();
        fetch_req_bf = 1'b0; dma_req = 1'b0; rst_l = 1'b1;
        repeat (2) step();

        // Zero-latency fetch, address truncated to the ICCM field.
        for (int i = 0; i < 3; i++) begin
            fetch_req_bf = 1'b1; fetch_addr_bf = fa[i];
            @(negedge clk);
            chk("fetch_gnt_lit", 64'(fetch_gnt), 64'd1);
            chk("fetch_addr_lit", 64'(iccm_rw_addr), 64'(ea[i]));
            step();
        end
        fetch_req_bf = 1'b0;
        step();

        // Full write with a simultaneous fetch: DMA first, fetch the next cycle.
        fetch_req_bf = 1'b1; fetch_addr_bf = 31'h100;
        dma_do(32'h40, 3'd3, 1'b1, 64'h1122_3344_5566_7788, 3'd1, r, w, f, ga);
        chk("wr64_wren", 64'(w), 64'd1);
        chk("wr64_rden", 64'(r), 64'd0);
        chk("wr64_fetch_blocked", 64'(f), 64'd0);
        @(negedge clk);
        chk("wr64_fetch_next", 64'(fetch_gnt), 64'd1);
        step();
        fetch_req_bf = 1'b0;
        step();

        read_check(32'h40, 3'd5, 64'h1122_3344_5566_7788);
        rmw_check(32'h43, 3'd0, {8{8'hA5}}, 3'd2, 64'h1122_3344_A566_7788);
        rmw_check(32'h47, 3'd1, {4{16'hBEEF}}, 3'd3, 64'hBEEF_3344_A566_7788);
        fetch_req_bf = 1'b1; fetch_addr_bf = 31'h200;
        rmw_check(32'h41, 3'd2, {2{32'hCAFE_F00D}}, 3'd4, 64'hBEEF_3344_CAFE_F00D);
        fetch_req_bf = 1'b0;
        step();
        read_check(32'h40, 3'd6, 64'hBEEF_3344_CAFE_F00D);

        // Reset during RMW_RD: the write is abandoned and memory keeps its old contents.
        dma_do(32'h80, 3'd0, 1'b1, {8{8'h3C}}, 3'd1, r, w, f, ga);
        rst_l = 1'b0;
        @(negedge clk);
        chk("rmw_rst_active", 64'(iccm_dma_active), 64'd0);
        chk("rmw_rst_idle", 64'(arb_idle), 64'd1);
        step();
        @(negedge clk);
        chk("rmw_rst_wren", 64'(iccm_wren), 64'd0);
        step();
        rst_l = 1'b1;
        step();
        read_check(32'h80, 3'd2, 64'h5A00_0010_FFFF_FFEF);

        // Reset during DMA_RD: no response is returned.
        dma_do(32'h88, 3'd3, 1'b0, '0, 3'd7, r, w, f, ga);
        rst_l = 1'b0;
        @(negedge clk);
        chk("rd_rst_rvalid_n1", 64'(dma_rvalid), 64'd0);
        step();
        @(negedge clk);
        chk("rd_rst_rvalid_n2", 64'(dma_rvalid), 64'd0);
        step();
        rst_l = 1'b1;
        repeat (2) step();

        // Continuous DMA full writes against a continuous fetch request.
        gcount = 0; gfirst = -1; glast = -1;
        fetch_req_bf = 1'b1; fetch_addr_bf = 31'h300;
        dma_req = 1'b1; dma_write = 1'b1; dma_sz = 3'd3; dma_addr = 32'h100; dma_tag = 3'd0;
        for (int i = 0; i < 12; i++) begin
            dma_wdata = 64'(i) | 64'hF00D_0000_0000_0000;
            @(negedge clk);
            if (fetch_gnt) begin
                gcount++;
                if (gfirst < 0) gfirst = i;
                glast = i;
            end
            step();
        end
        dma_req = 1'b0; fetch_req_bf = 1'b0;
`ifdef RV_ICCM_ARB_STARVE_EN
        chk("starve_gnt_count", 64'(gcount), 64'd2);
        chk("starve_first_gnt", 64'(gfirst), 64'd4);
        chk("starve_second_gnt", 64'(glast), 64'd9);
`else
        chk("strict_gnt_count", 64'(gcount), 64'd0);
`endif
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
